// File: rtl/serial_twos_converter_pkg.sv
// Shared definitions for the serial two's-complement converter:
// FSM state encoding and the operation mode codes.
package serial_twos_converter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [1:0] MODE_PASS = 2'b00;
  localparam logic [1:0] MODE_NEG  = 2'b01;
  localparam logic [1:0] MODE_ABS  = 2'b10;
  localparam logic [1:0] MODE_INV  = 2'b11;

endpackage

// File: rtl/serial_twos_converter_if.sv
// Operand/result bundle of the serial two's-complement converter.
interface serial_twos_converter_if #(
  parameter int WIDTH = 8
);
  // A transfer happens on a rising clk edge where valid && ready are both high.
  // The producer keeps valid and its payload stable until that edge; ready may
  // be high or low in any cycle and is never allowed to depend on a future valid.
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [1:0]       mode;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic             ovf;
  logic             busy;

  modport master (
    output in_valid, a, mode, out_ready,
    input  in_ready, out_valid, y, ovf, busy
  );

  modport slave (
    input  in_valid, a, mode, out_ready,
    output in_ready, out_valid, y, ovf, busy
  );
endinterface

// File: rtl/serial_twos_converter_digit_slice.sv
// One digit of the converter datapath: optional inversion followed by
// carry-in addition, producing a DIGIT-bit result and a carry out.
module twos_digit_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] digit,
  input  logic             invert,
  input  logic             carry_in,
  output logic [DIGIT-1:0] out_digit,
  output logic             carry_out
);

  logic [DIGIT-1:0] operand;
  logic [DIGIT:0]   sum;

  assign operand   = invert ? ~digit : digit;
  assign sum       = {1'b0, operand} + {{DIGIT{1'b0}}, carry_in};
  assign out_digit = sum[DIGIT-1:0];
  assign carry_out = sum[DIGIT];

endmodule

// File: rtl/serial_twos_converter.sv
// Multi-cycle two's-complement converter: pass, negate, abs and ones'
// complement, DIGIT bits per cycle LSB first, with a valid/ready handshake.
module serial_twos_converter
  import serial_twos_converter_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  serial_twos_converter_if.slave   bus,
  output state_t                   dbg_state
);

  localparam int NDIG  = WIDTH / DIGIT;
  localparam int CNT_W = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NDIG - 1);

  if (WIDTH < 2 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $error("serial_twos_converter: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state, state_nx;
  logic [WIDTH-1:0] sh;
  logic             carry;
  logic             invert;
  logic [CNT_W-1:0] cnt;
  logic             ovf_pend;
  logic [WIDTH-1:0] y_q;
  logic             ovf_q;
  logic             armed;
  logic             accept;
  logic [DIGIT-1:0] out_digit;
  logic             carry_out;
  logic [WIDTH-1:0] sh_nx;

  twos_digit_slice #(.DIGIT(DIGIT)) u_slice (
    .digit     (sh[DIGIT-1:0]),
    .invert    (invert),
    .carry_in  (carry),
    .out_digit (out_digit),
    .carry_out (carry_out)
  );

  // Operand bits leave at the LSB end while result digits enter at the MSB
  // end, so one register holds both; after NDIG shifts it is the result.
  assign sh_nx = (sh >> DIGIT) | (WIDTH'(out_digit) << (WIDTH - DIGIT));

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    case (state)
      IDLE: begin
        if (bus.in_valid && armed) begin
          accept   = 1'b1;
          state_nx = RUN;
        end
      end
      RUN: begin
        if (cnt == LAST_CNT) state_nx = DONE;
      end
      DONE: begin
        if (bus.out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // armed keeps in_ready low until the first edge after reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      armed    <= 1'b0;
      sh       <= '0;
      carry    <= 1'b0;
      invert   <= 1'b0;
      cnt      <= '0;
      ovf_pend <= 1'b0;
      y_q      <= '0;
      ovf_q    <= 1'b0;
    end else begin
      armed <= 1'b1;
      state <= state_nx;
      if (accept) begin
        sh       <= bus.a;
        cnt      <= '0;
        ovf_pend <= ((bus.mode == MODE_NEG) || (bus.mode == MODE_ABS)) &&
                    (bus.a == MIN_VAL);
        case (bus.mode)
          MODE_NEG: begin carry <= 1'b1;           invert <= 1'b1;           end
          MODE_ABS: begin carry <= bus.a[WIDTH-1]; invert <= bus.a[WIDTH-1]; end
          MODE_INV: begin carry <= 1'b0;           invert <= 1'b1;           end
          default:  begin carry <= 1'b0;           invert <= 1'b0;           end
        endcase
      end else if (state == RUN) begin
        sh    <= sh_nx;
        carry <= carry_out;
        cnt   <= cnt + CNT_W'(1);
        if (state_nx == DONE) begin
          y_q   <= sh_nx;
          ovf_q <= ovf_pend;
        end
      end
    end
  end

  assign bus.in_ready  = (state == IDLE) && armed;
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state == RUN);
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign dbg_state     = state;

endmodule
